// File: rtl/mram_axi_slave_ctrl.sv
// AXI slave front-end for the MRAM macro: splits INCR bursts into single-word macro
// requests, one burst at a time, with window range checking and ID-tagged B/R responses.
//
// state | meaning
// IDLE  | arbitrate AW/AR, capture id/addr/len and range result
// WDATA | pass W beats to the macro (or swallow them on error)
// WRESP | hold B response until bready
// RREQ  | issue one macro read (or skip it on error)
// RWAIT | wait for macro read data
// RRESP | hold R beat until rready
module mram_axi_slave_ctrl #(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0] MEM_BASE = '0,
  parameter int MEM_BYTES      = 65536,
  localparam int BYTES  = AXI_DATA_WIDTH / 8,
  localparam int BSH    = $clog2(BYTES),
  localparam int MEM_AW = $clog2(MEM_BYTES / BYTES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AXI_ID_WIDTH-1:0]   i_awid,
  input  logic [AXI_ADDR_WIDTH-1:0] i_awaddr,
  input  logic [7:0]                i_awlen,
  input  logic                      i_awvalid,
  output logic                      o_awready,
  input  logic [AXI_DATA_WIDTH-1:0] i_wdata,
  input  logic                      i_wlast,
  input  logic                      i_wvalid,
  output logic                      o_wready,
  output logic [AXI_ID_WIDTH-1:0]   o_bid,
  output logic [1:0]                o_bresp,
  output logic                      o_bvalid,
  input  logic                      i_bready,
  input  logic [AXI_ID_WIDTH-1:0]   i_arid,
  input  logic [AXI_ADDR_WIDTH-1:0] i_araddr,
  input  logic [7:0]                i_arlen,
  input  logic                      i_arvalid,
  output logic                      o_arready,
  output logic [AXI_ID_WIDTH-1:0]   o_rid,
  output logic [AXI_DATA_WIDTH-1:0] o_rdata,
  output logic [1:0]                o_rresp,
  output logic                      o_rlast,
  output logic                      o_rvalid,
  input  logic                      i_rready,
  output logic                      o_mem_req,
  output logic                      o_mem_we,
  output logic [MEM_AW-1:0]         o_mem_addr,
  output logic [AXI_DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                      i_mem_ready,
  input  logic                      i_mem_rvalid,
  input  logic [AXI_DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int EW = AXI_ADDR_WIDTH + 9;
  localparam logic [AXI_ADDR_WIDTH-1:0] LSB_MASK = AXI_ADDR_WIDTH'(BYTES - 1);
  localparam logic [EW-1:0] LIMIT = EW'(MEM_BASE) + EW'(MEM_BYTES);

  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RREQ, RWAIT, RRESP} state_t;

  state_t                    r_st;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [MEM_AW-1:0]         r_base;
  logic [7:0]                r_len;
  logic [7:0]                r_beat;
  logic                      r_err;
  logic                      r_last_wr;
  logic                      r_bvalid;
  logic [AXI_ID_WIDTH-1:0]   r_bid;
  logic [1:0]                r_bresp;
  logic                      r_rvalid;
  logic [AXI_ID_WIDTH-1:0]   r_rid;
  logic [1:0]                r_rresp;
  logic                      r_rlast;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;

  logic                      w_awready;
  logic                      w_arready;
  logic [AXI_ADDR_WIDTH-1:0] w_sel_addr;
  logic [AXI_ADDR_WIDTH-1:0] w_aligned;
  logic [AXI_ADDR_WIDTH-1:0] w_off;
  logic [7:0]                w_sel_len;
  logic [EW-1:0]             w_end;
  logic                      w_ok;
  logic [MEM_AW-1:0]         w_word;
  logic                      w_last_beat;
  logic                      w_wready;
  logic                      w_wfire;
  logic                      w_wlast_bad;
  logic                      w_mem_req;
  logic                      w_mem_we;
  logic [MEM_AW-1:0]         w_mem_addr;
  logic [AXI_DATA_WIDTH-1:0] w_mem_wdata;

  // Alternate writes and reads when both are pending; a write wins after reset.
  assign w_awready = (r_st == IDLE) && i_awvalid && (!i_arvalid || !r_last_wr);
  assign w_arready = (r_st == IDLE) && i_arvalid && !w_awready;

  assign w_sel_addr = w_awready ? i_awaddr : i_araddr;
  assign w_sel_len  = w_awready ? i_awlen  : i_arlen;
  assign w_aligned  = w_sel_addr & ~LSB_MASK;
  // Wide sum so a burst near the top of the address space cannot wrap into range.
  assign w_end      = EW'(w_aligned) + ((EW'(w_sel_len) + EW'(1)) << BSH);
  assign w_ok       = (EW'(w_aligned) >= EW'(MEM_BASE)) && (w_end <= LIMIT);
  assign w_off      = w_aligned - MEM_BASE;
  assign w_word     = MEM_AW'(w_off >> BSH);

  assign w_last_beat = (r_beat == r_len);
  assign w_wfire     = i_wvalid && w_wready;
  assign w_wlast_bad = (i_wlast != w_last_beat);

  always_comb begin
    w_wready    = 1'b0;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (r_st == WDATA) begin
      if (r_err) begin
        w_wready = 1'b1;
      end else begin
        w_wready    = i_mem_ready;
        w_mem_req   = i_wvalid;
        w_mem_we    = 1'b1;
        w_mem_addr  = r_base + MEM_AW'(r_beat);
        w_mem_wdata = i_wdata;
      end
    end else if (r_st == RREQ && !r_err) begin
      w_mem_req  = 1'b1;
      w_mem_addr = r_base + MEM_AW'(r_beat);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st      <= IDLE;
      r_id      <= '0;
      r_base    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_err     <= 1'b0;
      r_last_wr <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= '0;
      r_rvalid  <= 1'b0;
      r_rid     <= '0;
      r_rresp   <= '0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
    end else begin
      case (r_st)
        IDLE: begin
          if (w_awready || w_arready) begin
            r_id   <= w_awready ? i_awid : i_arid;
            r_base <= w_word;
            r_len  <= w_sel_len;
            r_beat <= '0;
            r_err  <= !w_ok;
            r_st   <= w_awready ? WDATA : RREQ;
          end
        end
        WDATA: begin
          if (w_wfire) begin
            if (w_wlast_bad) r_err <= 1'b1;
            if (w_last_beat) begin
              r_bvalid <= 1'b1;
              r_bid    <= r_id;
              r_bresp  <= (r_err || w_wlast_bad) ? 2'b10 : 2'b00;
              r_st     <= WRESP;
            end else begin
              r_beat <= r_beat + 8'd1;
            end
          end
        end
        WRESP: begin
          if (i_bready) begin
            r_bvalid  <= 1'b0;
            r_last_wr <= 1'b1;
            r_st      <= IDLE;
          end
        end
        RREQ: begin
          if (r_err) begin
            r_rvalid <= 1'b1;
            r_rid    <= r_id;
            r_rresp  <= 2'b10;
            r_rlast  <= w_last_beat;
            r_rdata  <= '0;
            r_st     <= RRESP;
          end else if (i_mem_ready) begin
            r_st <= RWAIT;
          end
        end
        RWAIT: begin
          if (i_mem_rvalid) begin
            r_rvalid <= 1'b1;
            r_rid    <= r_id;
            r_rresp  <= 2'b00;
            r_rlast  <= w_last_beat;
            r_rdata  <= i_mem_rdata;
            r_st     <= RRESP;
          end
        end
        RRESP: begin
          if (i_rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            if (r_rlast) begin
              r_last_wr <= 1'b0;
              r_st      <= IDLE;
            end else begin
              r_beat <= r_beat + 8'd1;
              r_st   <= RREQ;
            end
          end
        end
        default: r_st <= IDLE;
      endcase
    end
  end

  assign o_awready   = w_awready;
  assign o_arready   = w_arready;
  assign o_wready    = w_wready;
  assign o_bvalid    = r_bvalid;
  assign o_bid       = r_bid;
  assign o_bresp     = r_bresp;
  assign o_rvalid    = r_rvalid;
  assign o_rid       = r_rid;
  assign o_rresp     = r_rresp;
  assign o_rlast     = r_rlast;
  assign o_rdata     = r_rdata;
  assign o_mem_req   = w_mem_req;
  assign o_mem_we    = w_mem_we;
  assign o_mem_addr  = w_mem_addr;
  assign o_mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_mram_axi_slave_ctrl.sv
// Scoreboard bench for mram_axi_slave_ctrl: directed bursts push expected macro accesses
// and B/R responses; a negedge monitor pops and compares them as the DUT presents them.
module tb_mram_axi_slave_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  i_awid = '0;
  logic [31:0] i_awaddr = '0;
  logic [7:0]  i_awlen = '0;
  logic        i_awvalid = 1'b0;
  logic        o_awready;
  logic [63:0] i_wdata = '0;
  logic        i_wlast = 1'b0;
  logic        i_wvalid = 1'b0;
  logic        o_wready;
  logic [3:0]  o_bid;
  logic [1:0]  o_bresp;
  logic        o_bvalid;
  logic        i_bready = 1'b0;
  logic [3:0]  i_arid = '0;
  logic [31:0] i_araddr = '0;
  logic [7:0]  i_arlen = '0;
  logic        i_arvalid = 1'b0;
  logic        o_arready;
  logic [3:0]  o_rid;
  logic [63:0] o_rdata;
  logic [1:0]  o_rresp;
  logic        o_rlast;
  logic        o_rvalid;
  logic        i_rready = 1'b0;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [12:0] o_mem_addr;
  logic [63:0] o_mem_wdata;
  logic        i_mem_ready = 1'b1;
  logic        i_mem_rvalid = 1'b0;
  logic [63:0] i_mem_rdata = '0;

  mram_axi_slave_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wlast(i_wlast), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast), .o_rvalid(o_rvalid), .i_rready(i_rready),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_r;
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } resp_t;

  typedef struct packed {
    logic        we;
    logic [12:0] addr;
    logic [63:0] data;
  } mreq_t;

  resp_t       q_resp[$];
  mreq_t       q_mem[$];
  logic [63:0] mem_arr [0:8191];
  int          n_chk = 0;
  int          n_err = 0;
  int          m_lat = 1;
  int          m_cnt = 0;
  logic [12:0] m_addr = '0;
  int          b_stall = 0;
  int          r_stall = 0;
  int          b_wait = 0;
  int          r_wait = 0;
  logic        p_bhold = 1'b0;
  logic        p_rhold = 1'b0;
  logic [6:0]  p_b = '0;
  logic [71:0] p_r = '0;

  localparam logic [63:0] D1 = 64'h4D430000_A5A50000;
  localparam logic [63:0] D3 = 64'h33330000_33330000;
  localparam logic [63:0] D4 = 64'h88000000_88000000;

  function automatic logic [63:0] inc(input int i);
    return {32'(i), 32'(i)};
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s actual=timeout required=handshake", nm);
  endtask

  task automatic exp_b(input logic [3:0] id, input logic [1:0] resp);
    q_resp.push_back('{1'b0, id, 64'd0, resp, 1'b0});
  endtask

  task automatic exp_r(input logic [3:0] id, input logic [63:0] d, input logic [1:0] resp, input logic last);
    q_resp.push_back('{1'b1, id, d, resp, last});
  endtask

  task automatic exp_mw(input logic [12:0] a, input logic [63:0] d);
    q_mem.push_back('{1'b1, a, d});
  endtask

  task automatic exp_mr(input logic [12:0] a);
    q_mem.push_back('{1'b0, a, 64'd0});
  endtask

  // B/R ready drivers: hold ready low for a configurable number of cycles per response.
  always begin
    @(posedge clk); #1;
    if (o_bvalid) begin
      if (b_wait >= b_stall) i_bready = 1'b1;
      else begin i_bready = 1'b0; b_wait++; end
    end else begin
      i_bready = 1'b0; b_wait = 0;
    end
    if (o_rvalid) begin
      if (r_wait >= r_stall) i_rready = 1'b1;
      else begin i_rready = 1'b0; r_wait++; end
    end else begin
      i_rready = 1'b0; r_wait = 0;
    end
  end

  // Monitor plus macro model; everything is sampled half a cycle away from the active edge.
  always @(negedge clk) begin
    resp_t a;
    mreq_t m;
    i_mem_rvalid = 1'b0;
    if (!rst_n) begin
      m_cnt = 0;
      p_bhold = 1'b0;
      p_rhold = 1'b0;
    end else begin
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          i_mem_rvalid = 1'b1;
          i_mem_rdata  = mem_arr[m_addr];
        end
      end
      if (p_bhold) chk("b_held", 192'({o_bvalid, o_bid, o_bresp}), 192'(p_b));
      if (p_rhold) chk("r_held", 192'({o_rvalid, o_rid, o_rdata, o_rresp, o_rlast}), 192'(p_r));
      p_bhold = o_bvalid && !i_bready;
      p_rhold = o_rvalid && !i_rready;
      p_b = {o_bvalid, o_bid, o_bresp};
      p_r = {o_rvalid, o_rid, o_rdata, o_rresp, o_rlast};
      if (o_bvalid && i_bready) begin
        a = '{1'b0, o_bid, 64'd0, o_bresp, 1'b0};
        if (q_resp.size() == 0) chk("b_unexpected", 192'(a), 192'(0));
        else chk("b_resp", 192'(a), 192'(q_resp.pop_front()));
      end
      if (o_rvalid && i_rready) begin
        a = '{1'b1, o_rid, o_rdata, o_rresp, o_rlast};
        if (q_resp.size() == 0) chk("r_unexpected", 192'(a), 192'(0));
        else chk("r_beat", 192'(a), 192'(q_resp.pop_front()));
      end
      if (o_mem_req && i_mem_ready) begin
        m = '{o_mem_we, o_mem_addr, o_mem_we ? o_mem_wdata : 64'd0};
        if (q_mem.size() == 0) chk("mem_unexpected", 192'(m), 192'(0));
        else chk("mem_access", 192'(m), 192'(q_mem.pop_front()));
        if (o_mem_we) mem_arr[o_mem_addr] = o_mem_wdata;
        else begin m_addr = o_mem_addr; m_cnt = m_lat; end
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk(nm, 192'({o_awready, o_wready, o_bid, o_bresp, o_bvalid, o_arready, o_rid, o_rdata, o_rresp,
                  o_rlast, o_rvalid, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata}), 192'(0));
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int t = 0;
    i_awid = id; i_awaddr = addr; i_awlen = len; i_awvalid = 1'b1;
    do begin @(negedge clk); t++; end while (!o_awready && t < 400);
    if (!o_awready) fail_now("aw_timeout");
    @(posedge clk); #1;
    i_awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int t = 0;
    i_arid = id; i_araddr = addr; i_arlen = len; i_arvalid = 1'b1;
    do begin @(negedge clk); t++; end while (!o_arready && t < 400);
    if (!o_arready) fail_now("ar_timeout");
    @(posedge clk); #1;
    i_arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic last);
    int t = 0;
    i_wdata = d; i_wlast = last; i_wvalid = 1'b1;
    do begin @(negedge clk); t++; end while (!o_wready && t < 400);
    if (!o_wready) fail_now("w_timeout");
    @(posedge clk); #1;
    i_wvalid = 1'b0; i_wlast = 1'b0;
  endtask

  // W beats are offered concurrently with AW so early data must be held off by the DUT.
  task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [63:0] d0, input int wl_at, input int nbeats);
    fork
      send_aw(id, addr, 8'(len));
      for (int i = 0; i < nbeats; i++) send_w(d0 + inc(i), i == wl_at);
    join
  endtask

  task automatic drain();
    int t = 0;
    while ((q_resp.size() != 0 || q_mem.size() != 0) && t < 3000) begin @(posedge clk); t++; end
    if (t >= 3000) begin
      fail_now("drain_timeout");
      q_resp.delete();
      q_mem.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    #1;
    chk_zero(nm);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    chk_zero("reset_outputs");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: MCU sequence, write then read back
    for (int i = 0; i < 4; i++) exp_mw(13'h200 + 13'(i), D1 + inc(i));
    exp_b(4'd1, 2'b00);
    wr_burst(4'd1, 32'h1000, 3, D1, 3, 4);
    drain();
    for (int i = 0; i < 4; i++) exp_mr(13'h200 + 13'(i));
    for (int i = 0; i < 4; i++) exp_r(4'd1, D1 + inc(i), 2'b00, i == 3);
    send_ar(4'd1, 32'h1000, 8'd3);
    drain();

    // 2: out-of-range burst straddling the top of the window
    exp_b(4'd2, 2'b10);
    wr_burst(4'd2, 32'h0000_FFF8, 1, 64'hDEAD, 1, 2);
    drain();
    exp_r(4'd2, 64'd0, 2'b10, 1'b0);
    exp_r(4'd2, 64'd0, 2'b10, 1'b1);
    send_ar(4'd2, 32'h0000_FFF8, 8'd1);
    drain();

    // 3: simultaneous AW/AR, write first after reset, then read first after a write
    do_reset("reset_mid_run");
    exp_mw(13'h400, D3); exp_mw(13'h401, D3 + inc(1));
    exp_b(4'd3, 2'b00);
    exp_mr(13'h200);
    exp_r(4'd4, D1, 2'b00, 1'b1);
    fork
      wr_burst(4'd3, 32'h2000, 1, D3, 1, 2);
      send_ar(4'd4, 32'h1000, 8'd0);
    join
    drain();
    exp_mw(13'h600, 64'h5555);
    exp_b(4'd5, 2'b00);
    wr_burst(4'd5, 32'h3000, 0, 64'h5555, 0, 1);
    drain();
    exp_mr(13'h400); exp_mr(13'h401);
    exp_r(4'd7, D3, 2'b00, 1'b0);
    exp_r(4'd7, D3 + inc(1), 2'b00, 1'b1);
    exp_mw(13'h601, 64'h6666);
    exp_b(4'd6, 2'b00);
    fork
      wr_burst(4'd6, 32'h3008, 0, 64'h6666, 0, 1);
      send_ar(4'd7, 32'h2000, 8'd1);
    join
    drain();

    // 4: macro and response backpressure
    m_lat = 3; b_stall = 4; r_stall = 3;
    for (int i = 0; i < 8; i++) exp_mw(13'h800 + 13'(i), D4 + inc(i));
    exp_b(4'd8, 2'b00);
    fork
      wr_burst(4'd8, 32'h4000, 7, D4, 7, 8);
      begin
        repeat (4) @(posedge clk);
        #1 i_mem_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 i_mem_ready = 1'b1;
      end
    join
    drain();
    for (int i = 0; i < 8; i++) exp_mr(13'h800 + 13'(i));
    for (int i = 0; i < 8; i++) exp_r(4'd8, D4 + inc(i), 2'b00, i == 7);
    send_ar(4'd8, 32'h4000, 8'd7);
    drain();
    m_lat = 1; b_stall = 0; r_stall = 0;

    // 5: early wlast; the macro sees beats up to the bad one, the rest are swallowed
    exp_mw(13'hA00, 64'h9900); exp_mw(13'hA01, 64'h9900 + inc(1));
    exp_b(4'd9, 2'b10);
    wr_burst(4'd9, 32'h5000, 3, 64'h9900, 1, 4);
    drain();

    // 6: reset while beat 2 of a write is on the bus
    exp_mw(13'hC00, 64'hAA00); exp_mw(13'hC01, 64'hAA00 + inc(1));
    wr_burst(4'd10, 32'h6000, 3, 64'hAA00, 3, 2);
    i_wdata = 64'hAA00 + inc(2); i_wvalid = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_zero("reset_async_wdata");
    i_wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drain();
    exp_mw(13'hC00, 64'hBB00); exp_mw(13'hC01, 64'hBB00 + inc(1));
    exp_b(4'd11, 2'b00);
    wr_burst(4'd11, 32'h6000, 1, 64'hBB00, 1, 2);
    drain();
    exp_mr(13'hC00); exp_mr(13'hC01);
    exp_r(4'd12, 64'hBB00, 2'b00, 1'b0);
    exp_r(4'd12, 64'hBB00 + inc(1), 2'b00, 1'b1);
    send_ar(4'd12, 32'h6000, 8'd1);
    drain();
    repeat (10) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
